// File: rtl/uart_pkg.sv
// Shared UART constants and TX FSM state encoding.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int   UART_FRAME_BITS = 11;
`else
    localparam int   UART_FRAME_BITS = 10;
`endif
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmit queue, with registered full/empty flags.
// Show-ahead read: pop_data always presents the oldest entry while not empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [AW:0]               level
);

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic [AW:0]               count_next;
    logic                      do_push;
    logic                      do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Flags are derived from the next count so they stay registered yet exact.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer, LSB first, divisor-timed bits.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [UART_DATA_BITS-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    input  logic [DIV_W-1:0]          baud_div_i,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic [LVL_W-1:0]          fifo_level_o
);

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [2:0]                idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      ready_en_q;
    logic                      load;
    logic                      bit_end;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    logic                      par_q;
`endif

    assign tx_ready_o = ready_en_q && !fifo_full;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign bit_end    = (cnt_q == '0);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .push      (tx_valid_i && tx_ready_o),
        .push_data (tx_data_i),
        .pop       (load),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        load    = 1'b0;

        if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - DIV_W'(1);

        // tx_d is the level for the bit that begins on the coming edge.
        case (state_q)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = div_q;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    cnt_d   = div_q;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        tx_d    = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase

        // Shared by IDLE and STOP so back-to-back frames start with no idle clock.
        if (load) begin
            state_d = ST_START;
            shift_d = fifo_rd_data;
            div_d   = baud_div_i;
            cnt_d   = baud_div_i;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)  par_q <= 1'b0;
        else if (load) par_q <= ^fifo_rd_data;
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer; define UART_TX_PARITY_EN to test the parity build.
module tb_uart_tx_serializer;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic [7:0]       tx_data_i = '0;
    logic             tx_valid_i = 1'b0;
    logic             tx_ready_o;
    logic [DIV_W-1:0] baud_div_i = 16'd3;
    logic             tx_o;
    logic             busy_o;
    logic [2:0]       fifo_level_o;

    int   checks = 0;
    int   errors = 0;
    bit   cap_en = 1'b0;
    logic cap[$];
    logic exp_q[$];

    uart_tx_serializer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .baud_div_i   (baud_div_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Line monitor: one sample per clock, taken mid-cycle.
    always @(negedge wb_clk_i) if (cap_en) cap.push_back(tx_o);

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic start_capture();
        cap.delete();
        exp_q.delete();
        cap_en = 1'b1;
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[j])
            for (int k = 0; k <= div; k++) exp_q.push_back(bits[j]);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!tx_ready_o && n < 500) begin
            tick();
            n++;
        end
        if (!tx_ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_wait: tx_ready_o=%b after %0d clocks, required 1", tx_ready_o, n);
        end
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy_o && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: busy_o=%b after %0d clocks, required 0", name, busy_o, n);
        end
        repeat (3) tick();
        cap_en = 1'b0;
    endtask

    // Captured line must match exp_q from the first start bit on, then stay idle high.
    task automatic compare_stream(input string name);
        int   start = -1;
        int   bad = -1;
        logic got = 1'b1;
        logic want = 1'b1;
        foreach (cap[i]) if (start < 0 && cap[i] === 1'b0) start = i;
        checks++;
        if (start < 0) begin
            errors++;
            $display("[TB] FAIL %s_stream: tx_o stayed high for all %0d samples, required a start bit", name, cap.size());
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i >= cap.size() || cap[start + i] !== exp_q[i]) begin
                bad  = i;
                want = exp_q[i];
                got  = (start + i < cap.size()) ? cap[start + i] : 1'bx;
                break;
            end
        end
        if (bad < 0) begin
            for (int i = start + exp_q.size(); i < cap.size(); i++) begin
                if (cap[i] !== 1'b1) begin
                    bad  = i - start;
                    got  = cap[i];
                    want = 1'b1;
                    break;
                end
            end
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s_stream: bit-clock %0d tx_o=%b, required %b", name, bad, got, want);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b, required 1", tx_o); end
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy_o); end
        if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, required 0", fifo_level_o); end
        if (tx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 0", tx_ready_o); end
        wb_rst_i = 1'b0;
        tick();
        checks++;
        if (tx_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b, required 1", tx_ready_o); end
    endtask

    task automatic test_single_frame();
        int n = 0;
        baud_div_i = 16'd3;
        start_capture();
        push_byte(8'hA5);
        checks += 2;
        if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_at_n: got %b, required 1", tx_o); end
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_at_n: got %b, required 0", busy_o); end
        tick();
        checks += 2;
        if (tx_o !== 1'b0) begin errors++; $display("[TB] FAIL single_start_n1: got %b, required 0", tx_o); end
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_n1: got %b, required 1", busy_o); end
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4 * FRAME_BITS) begin
            errors++;
            $display("[TB] FAIL single_frame_len: busy for %0d clocks, required %0d", n, 4 * FRAME_BITS);
        end
        repeat (3) tick();
        cap_en = 1'b0;
        add_frame(8'hA5, 3);
        compare_stream("single");
    endtask

    task automatic test_back_to_back();
        baud_div_i = 16'd0;
        start_capture();
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h00; tick();
        tx_data_i  = 8'hFF; tick();
        tx_data_i  = 8'h55; tick();
        tx_valid_i = 1'b0;
        checks++;
        if (fifo_level_o !== 3'd2) begin errors++; $display("[TB] FAIL b2b_level: got %0d, required 2", fifo_level_o); end
        wait_idle("b2b", 100);
        add_frame(8'h00, 0);
        add_frame(8'hFF, 0);
        add_frame(8'h55, 0);
        compare_stream("b2b");
        checks++;
        if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL b2b_level_end: got %0d, required 0", fifo_level_o); end
    endtask

    task automatic test_fill_full();
        logic [7:0] bytes [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        int n = 0;
        int want_wait = 1 + 2 * FRAME_BITS - FIFO_DEPTH;
        baud_div_i = 16'd1;
        start_capture();
        tx_valid_i = 1'b1;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            tx_data_i = bytes[i];
            tick();
        end
        tx_valid_i = 1'b0;
        checks += 2;
        if (tx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b, required 0", tx_ready_o); end
        if (fifo_level_o !== 3'(FIFO_DEPTH)) begin errors++; $display("[TB] FAIL full_level: got %0d, required %0d", fifo_level_o, FIFO_DEPTH); end
        while (!tx_ready_o && n < 200) begin
            tick();
            n++;
        end
        checks += 2;
        if (n !== want_wait) begin errors++; $display("[TB] FAIL full_ready_rise: after %0d clocks, required %0d", n, want_wait); end
        if (fifo_level_o !== 3'(FIFO_DEPTH - 1)) begin errors++; $display("[TB] FAIL full_level_pop: got %0d, required %0d", fifo_level_o, FIFO_DEPTH - 1); end
        push_byte(bytes[5]);
        wait_idle("full", 600);
        for (int i = 0; i < 6; i++) add_frame(bytes[i], 1);
        compare_stream("full");
    endtask

    task automatic test_reset_mid_frame();
        int zeros = 0;
        baud_div_i = 16'd1;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h3C; tick();
        tx_data_i  = 8'h11; tick();
        tx_data_i  = 8'h22; tick();
        tx_valid_i = 1'b0;
        repeat (10) tick();
        checks += 3;
        if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_bit4: got %b, required 1", tx_o); end
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_pre: got %b, required 1", busy_o); end
        if (fifo_level_o !== 3'd2) begin errors++; $display("[TB] FAIL midrst_level_pre: got %0d, required 2", fifo_level_o); end
        wb_rst_i = 1'b1;
        tick();
        checks += 3;
        if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tx: got %b, required 1", tx_o); end
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy_o); end
        if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL midrst_level: got %0d, required 0", fifo_level_o); end
        wb_rst_i = 1'b0;
        start_capture();
        repeat (60) tick();
        cap_en = 1'b0;
        foreach (cap[i]) if (cap[i] !== 1'b1) zeros++;
        checks += 2;
        if (zeros != 0) begin errors++; $display("[TB] FAIL midrst_quiet: %0d non-idle samples, required 0", zeros); end
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_after: got %b, required 0", busy_o); end
    endtask

    task automatic test_baud_change();
        baud_div_i = 16'd1;
        start_capture();
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h96; tick();
        tx_data_i  = 8'h69; tick();
        tx_valid_i = 1'b0;
        repeat (4) tick();
        baud_div_i = 16'd7;
        wait_idle("baud", 400);
        add_frame(8'h96, 1);
        add_frame(8'h69, 7);
        compare_stream("baud");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int start = -1;
        baud_div_i = 16'd0;
        start_capture();
        push_byte(8'h07);
        push_byte(8'h03);
        wait_idle("parity", 100);
        foreach (cap[i]) if (start < 0 && cap[i] === 1'b0) start = i;
        checks += 2;
        if (start < 0 || start + 20 >= cap.size()) begin
            errors += 2;
            $display("[TB] FAIL parity_capture: start=%0d size=%0d, required a full capture", start, cap.size());
        end else begin
            if (cap[start + 9] !== 1'b1) begin errors++; $display("[TB] FAIL parity_07: got %b, required 1", cap[start + 9]); end
            if (cap[start + 20] !== 1'b0) begin errors++; $display("[TB] FAIL parity_03: got %b, required 0", cap[start + 20]); end
        end
        add_frame(8'h07, 0);
        add_frame(8'h03, 0);
        compare_stream("parity");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fill_full();
        test_reset_mid_frame();
        test_baud_change();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
